// File: rtl/instr_mem_sync.sv
// -----------------------------------------------------------------------------
// instr_mem_sync
//
// Synchronous-read, byte-addressed, big-endian instruction memory. It sits
// between the PC register and the decoder of the cores.
//
// Word organisation: DEPTH_BYTES/4 words of 32 bits. A byte address selects
// word addr/4 and lane addr[1:0]; lane 0 is bits 31:24, so the byte at the
// fetch address is the most significant byte of the instruction.
//
// After every reset the whole array is zeroed, one word per cycle (CLEAR
// state). Fetches and loads are only accepted once the block is in RUN.
//
// Ports
//   clk          in   single clock, all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   fetch_req    in   fetch request
//   fetch_addr   in   byte address of the instruction (PC)
//   fetch_ready  out  fetch accepted this cycle if fetch_req is high
//   instr_valid  out  instr / fetch_err valid this cycle
//   instr        out  fetched instruction word (big-endian)
//   fetch_err    out  last fetch was misaligned or out of range
//   load_en      in   write one byte into the array
//   load_addr    in   byte address for the load
//   load_data    in   byte to write
//   load_ready   out  load accepted this cycle if load_en is high
//   clearing     out  array clear in progress
// -----------------------------------------------------------------------------
module instr_mem_sync #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic                  fetch_err,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic                  load_ready,
  output logic                  clearing
);

  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned WORD_AW     = $clog2(DEPTH_WORDS);

  // Range limits are held one bit wider than the address so that a depth
  // equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH:0] LAST_EXT  = (ADDR_WIDTH + 1)'(DEPTH_BYTES - 4);
  localparam logic [WORD_AW-1:0]  CNT_LAST  = WORD_AW'(DEPTH_WORDS - 1);
  localparam logic [WORD_AW-1:0]  CNT_ONE   = WORD_AW'(1);
  localparam logic [WORD_AW-1:0]  CNT_ZERO  = WORD_AW'(0);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e             state_q;
  state_e             state_d;
  logic [WORD_AW-1:0] clr_cnt_q;
  logic [WORD_AW-1:0] clr_cnt_d;

  logic               instr_valid_q;
  logic               instr_valid_d;
  logic [31:0]        instr_q;
  logic [31:0]        instr_d;
  logic               fetch_err_q;
  logic               fetch_err_d;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               run_s;
  logic               clr_we_s;
  logic               fetch_acc_s;
  logic               fetch_misalign_s;
  logic               fetch_oob_s;
  logic               fetch_bad_s;
  logic [WORD_AW-1:0] fetch_idx_s;
  logic [31:0]        fetch_word_s;
  logic               load_acc_s;
  logic               load_in_range_s;
  logic               load_we_s;
  logic [WORD_AW-1:0] load_idx_s;
  logic [3:0]         load_be_s;

  // ---------------------------------------------------------------------------
  // Handshake and status outputs
  // ---------------------------------------------------------------------------
  assign run_s       = (state_q == ST_RUN);
  assign clearing    = (state_q == ST_CLEAR);
  assign load_ready  = run_s;
  // A load owns the array for its cycle, so it stalls any fetch.
  assign fetch_ready = run_s && !load_en;

  assign fetch_acc_s = fetch_req && fetch_ready;
  assign load_acc_s  = load_en && load_ready;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // Full-width compares: any set high bit is out of range, never wrapped.
  assign fetch_misalign_s = (fetch_addr[1:0] != 2'b00);
  assign fetch_oob_s      = ({1'b0, fetch_addr} > LAST_EXT);
  assign fetch_bad_s      = fetch_misalign_s || fetch_oob_s;
  assign fetch_idx_s      = fetch_addr[WORD_AW+1:2];

  assign load_in_range_s  = ({1'b0, load_addr} < DEPTH_EXT);
  assign load_we_s        = load_acc_s && load_in_range_s;
  assign load_idx_s       = load_addr[WORD_AW+1:2];

  // Byte-enable for the addressed lane; lane 0 maps to bits 31:24.
  always_comb begin
    load_be_s = 4'b0000;
    case (load_addr[1:0])
      2'b00:   load_be_s = 4'b1000;
      2'b01:   load_be_s = 4'b0100;
      2'b10:   load_be_s = 4'b0010;
      2'b11:   load_be_s = 4'b0001;
      default: load_be_s = 4'b0000;
    endcase
  end

  // Read word selection; an erroring fetch never touches the array.
  always_comb begin
    fetch_word_s = NOP_WORD;
    if (fetch_bad_s) begin
      fetch_word_s = NOP_WORD;
    end else begin
      fetch_word_s = mem_q[fetch_idx_s];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state logic: CLEAR walks the counter over every word, then RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_s  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_cnt_q == CNT_LAST) begin
          state_d   = ST_RUN;
          clr_cnt_d = CNT_ZERO;
        end else begin
          state_d   = ST_CLEAR;
          clr_cnt_d = clr_cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        state_d   = ST_RUN;
        clr_cnt_d = CNT_ZERO;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // State and clear-counter registers; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch pipeline register
  // ---------------------------------------------------------------------------
  // Next fetch result: valid follows acceptance, data holds when idle.
  always_comb begin
    instr_valid_d = fetch_acc_s;
    instr_d       = instr_q;
    fetch_err_d   = fetch_err_q;
    if (fetch_acc_s) begin
      instr_d     = fetch_word_s;
      fetch_err_d = fetch_bad_s;
    end else begin
      instr_d     = instr_q;
      fetch_err_d = fetch_err_q;
    end
  end

  // Fetch output registers; reset aborts any in-flight fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h00000000;
      fetch_err_q   <= 1'b0;
    end else begin
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign fetch_err   = fetch_err_q;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // Array writes: clear sweep during CLEAR, byte loads during RUN (disjoint).
  always_ff @(posedge clk) begin
    if (clr_we_s && !reset) begin
      mem_q[clr_cnt_q] <= 32'h00000000;
    end else if (load_we_s && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (load_be_s[b]) begin
          mem_q[load_idx_s][8*b +: 8] <= load_data;
        end else begin
          mem_q[load_idx_s][8*b +: 8] <= mem_q[load_idx_s][8*b +: 8];
        end
      end
    end else begin
      mem_q <= mem_q;
    end
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
Parametrised, synchronous-read instruction memory that succeeds the fixed 56-byte, reset-initialised instruction store. It is byte-addressed and big-endian: the byte at the fetch address is instruction bits 31:24. The block adds four features: a byte-wide program-load port, a registered fetch with request/valid handshake, hardware clear of the whole array after reset, and error flagging for misaligned or out-of-range fetches. It sits between the PC register and the decoder/control unit of the single-cycle and pipelined cores.

Parameters:
ADDR_WIDTH, 32, width of fetch_addr and load_addr (byte addresses)
DEPTH_BYTES, 256, memory size in bytes; must be a multiple of 4 and at least 8
NOP_WORD, 32'h00000000, instruction returned on an erroring fetch

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
fetch_req  input  1  fetch request
fetch_addr  input  ADDR_WIDTH  byte address of the instruction (PC)
fetch_ready  output  1  a fetch is accepted this cycle if fetch_req is also high
instr_valid  output  1  instr and fetch_err are valid this cycle
instr  output  32  fetched instruction word, big-endian
fetch_err  output  1  last fetch was misaligned or out of range
load_en  input  1  write one byte into the array
load_addr  input  ADDR_WIDTH  byte address for the load
load_data  input  8  byte to write
load_ready  output  1  a load is accepted this cycle if load_en is also high
clearing  output  1  array clear in progress

Behaviour:
- Storage: DEPTH_BYTES/4 words of 32 bits, with a byte write enable per word. Word index = addr / 4. Byte lane = addr[1:0]; lane 0 is bits 31:24.
- State machine, two states:
  - CLEAR: entered on any cycle with reset=1. A clear counter starts at 0. Each cycle one word is written to 0 and the counter increments. After DEPTH_BYTES/4 words are cleared, the next cycle is RUN.
  - RUN: normal operation; stays in RUN until reset.
  - Clear duration is exactly DEPTH_BYTES/4 cycles after reset deasserts.
- Reset values:
  - instr_valid=0, instr=0, fetch_err=0
  - fetch_ready=0, load_ready=0, clearing=1
  - clear counter=0
- clearing = (state==CLEAR).
- load_ready = (state==RUN).
- fetch_ready = (state==RUN) && !load_en. A load has priority and stalls a fetch for that cycle.
- Load rules:
  - Accepted when load_en && load_ready.
  - If load_addr < DEPTH_BYTES, byte lane load_addr[1:0] of word load_addr/4 is written at the clock edge.
  - If load_addr is out of range, the load is silently dropped.
  - Loads during CLEAR are ignored.
- Fetch rules:
  - A fetch is accepted when fetch_req && fetch_ready.
  - Latency is 1: on the edge after acceptance, instr_valid=1 and instr holds the word for the following cycle.
  - Each cycle with no accepted fetch gives instr_valid=0 on the next cycle. instr holds its last value in that case.
- Error rules:
  - Condition: fetch_addr[1:0] != 0, or fetch_addr > DEPTH_BYTES-4.
  - Response: instr=NOP_WORD, fetch_err=1, instr_valid=1.
  - Otherwise fetch_err=0.
  - fetch_err is meaningful only while instr_valid=1.
- Ordering: a byte loaded in cycle N is visible to a fetch accepted in cycle N+1 or later. A same-cycle load and fetch cannot occur because fetch_ready is gated by load_en.
- Back-to-back fetches every cycle are supported, giving one instruction per cycle.
- Address width: the comparison uses the full ADDR_WIDTH. No address wrap: high bits set means out of range.
- Reset mid-operation:
  - Aborts any in-flight fetch: instr_valid=0 on the next cycle.
  - Returns to CLEAR with the counter at 0.
  - Discards all loaded content.
- Reset asserted during CLEAR restarts the clear from word 0.

Test Plan:
1. Reset for 2 cycles, then release (DEPTH_BYTES=256) -> clearing=1 and fetch_ready=0 for exactly 64 cycles, then clearing=0 and fetch_ready=1; fetch of 0x00 -> instr=0x00000000, fetch_err=0.
2. Load bytes 0x00,0x01,0x10,0x20 at addresses 0..3 and 0xAC,0x62,0x00,0x20 at 4..7; then fetch 0 and 4 on consecutive cycles -> instr_valid on each following cycle with instr=0x00011020, then 0xAC620020.
3. Fetch addresses 0x02 and 0x100 -> instr=0x00000000, fetch_err=1, instr_valid=1; fetch 0xFC -> fetch_err=0.
4. Hold fetch_req=1 while load_en=1 for 3 cycles -> fetch_ready=0 and no instr_valid during those cycles; fetch resumes the cycle load_en drops. Load 0xFF to address 3, then fetch 0 the next cycle -> instr=0x000110FF.
5. Assert reset during a fetch stream in RUN -> instr_valid=0 next cycle, the 64-cycle clear reruns, and a fetch of 0 afterwards returns 0x00000000.
6. Assert load_en at address 8 during CLEAR -> load_ready=0; after clear, fetch 8 -> instr=0x00000000.
